// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM states and port indices.
package cpu_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous write and registered read; only the read register is reset.
module dmem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only moves on a load, so stores never disturb the last load result.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port data RAM, one access per two cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to port 0.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [7:0]            conflict_cnt
);

    // state  | meaning
    // IDLE   | no access in flight; samples req
    // ACCESS | winner granted; RAM read/write at closing edge
    // RESP   | load data valid (if load); samples req again

    arb_state_e state_q, state_d;

    logic                  win_q, win_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  sample;
    logic                  launch;

    assign sample = (state_q == IDLE) || (state_q == RESP);
    assign launch = sample && (req != 2'b00);

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_comb begin
        win_d = PORT_CPU;
        if (req == 2'b11) begin
            win_d = ~last_q;
        end else if (req[1]) begin
            win_d = PORT_DBG;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_q <= PORT_DBG;
        end else if (launch) begin
            last_q <= win_d;
        end
    end
`else
    always_comb begin
        win_d = req[0] ? PORT_CPU : PORT_DBG;
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        rvalid  = 2'b00;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (launch) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                gnt     = win_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: begin
                if (!we_q) begin
                    rvalid = win_q ? 2'b10 : 2'b01;
                end
                state_d = launch ? ACCESS : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Winner's request is captured at the sampling edge; requesters may drop req during gnt.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            win_q   <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (launch) begin
            win_q   <= win_d;
            we_q    <= win_d ? we[1] : we[0];
            addr_q  <= win_d ? addr1 : addr0;
            wdata_q <= win_d ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            conflict_cnt <= 8'd0;
        end else if (sample && (req == 2'b11) && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

    // Reset drops state to IDLE asynchronously, so a write pending in ACCESS never reaches the RAM.
    dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .nreset (nreset),
        .en     (state_q == ACCESS),
        .we     (we_q),
        .addr   (addr_q),
        .wdata  (wdata_q),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; expectations follow the build (DMEM_ARB_RR_EN or not).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  conflict_cnt;

    int vectors    = 0;
    int miscompares = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int port, input logic w, input logic [4:0] a, input logic [31:0] d);
        if (port == 1) begin
            we[1] = w; addr1 = a; wdata1 = d; req[1] = 1'b1;
        end else begin
            we[0] = w; addr0 = a; wdata0 = d; req[0] = 1'b1;
        end
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
    task automatic single(input string tag, input int port, input logic w, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata);
        logic [1:0] onehot;
        onehot = (port == 1) ? 2'b10 : 2'b01;
        issue(port, w, a, d);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(onehot));
        req[port] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(rvalid), w ? 32'd0 : 32'(onehot));
        if (!w) check({tag, "_rdata"}, rdata, exp_rdata);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_d;

        nreset = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #1;
        check("rst_gnt",    32'(gnt),    32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_rdata",  rdata,       32'd0);
        check("rst_cnt",    32'(conflict_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        // store then load on port 0
        single("st3", 0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0);
        single("ld3", 0, 1'b0, 5'd3, 32'h0, 32'hDEADBEEF);

        // simultaneous loads, port 0 wins first
        single("st1", 0, 1'b1, 5'd1, 32'h000000A1, 32'h0);
        single("st2", 1, 1'b1, 5'd2, 32'h000000B2, 32'h0);
        issue(0, 1'b0, 5'd1, 32'h0);
        issue(1, 1'b0, 5'd2, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("both_gnt_first", 32'(gnt), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("both_rvalid_first", 32'(rvalid), 32'd1);
        check("both_rdata_first", rdata, 32'h000000A1);
        @(negedge clk);
        check("both_gnt_second", 32'(gnt), 32'd2);
        req[1] = 1'b0;
        @(negedge clk);
        check("both_rvalid_second", 32'(rvalid), 32'd2);
        check("both_rdata_second", rdata, 32'h000000B2);
        check("both_cnt", 32'(conflict_cnt), 32'd1);
        @(negedge clk);
        check("both_idle", 32'(busy), 32'd0);

        // both ports requesting continuously for 8 grants
        issue(0, 1'b0, 5'd1, 32'h0);
        issue(1, 1'b0, 5'd2, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            exp_d = exp_g[1] ? 32'h000000B2 : 32'h000000A1;
            @(negedge clk);
            check($sformatf("cont_gnt%0d", i), 32'(gnt), 32'(exp_g));
            @(negedge clk);
            check($sformatf("cont_rvalid%0d", i), 32'(rvalid), 32'(exp_g));
            check($sformatf("cont_rdata%0d", i), rdata, exp_d);
            if (i == 7) req = 2'b00;
        end
        @(negedge clk);
        check("cont_cnt", 32'(conflict_cnt), 32'd9);
        check("cont_idle", 32'(busy), 32'd0);

        // reset during ACCESS of a store suppresses the write
        single("st7", 0, 1'b1, 5'd7, 32'h00000011, 32'h0);
        issue(0, 1'b1, 5'd7, 32'h00000099);
        @(posedge clk);
        @(negedge clk);
        check("rstacc_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        #1 nreset = 1'b0;
        #1;
        check("rstacc_gnt0",   32'(gnt),    32'd0);
        check("rstacc_rvalid", 32'(rvalid), 32'd0);
        check("rstacc_busy",   32'(busy),   32'd0);
        check("rstacc_rdata",  rdata,       32'd0);
        check("rstacc_cnt",    32'(conflict_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        single("ld7", 0, 1'b0, 5'd7, 32'h0, 32'h00000011);

        // top address does not alias address 0
        single("st0", 0, 1'b1, 5'd0, 32'h00000A0A, 32'h0);
        single("st31", 1, 1'b1, 5'd31, 32'h31313131, 32'h0);
        single("ld31", 0, 1'b0, 5'd31, 32'h0, 32'h31313131);
        single("ld0", 1, 1'b0, 5'd0, 32'h0, 32'h00000A0A);
        single("st5", 1, 1'b1, 5'd5, 32'h00000055, 32'h0);
        check("rdata_kept_after_store", rdata, 32'h00000A0A);

        // conflict counter saturation
        issue(0, 1'b0, 5'd3, 32'h0);
        issue(1, 1'b0, 5'd31, 32'h0);
        repeat (399) @(posedge clk);
        @(negedge clk);
        check("sat_cnt200", 32'(conflict_cnt), 32'd200);
        repeat (200) @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        check("sat_cnt255", 32'(conflict_cnt), 32'd255);
        repeat (4) @(negedge clk);
        check("sat_cnt_hold", 32'(conflict_cnt), 32'd255);
        check("sat_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, word address width (32 words).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port nreset  input  1  asynchronous, active-low reset.
REQ-005 Port req[1:0]  input  2  access request; bit 0 = CPU load/store unit, bit 1 = debug port.
REQ-006 Port we[1:0]  input  2  per-port write enable (1 = store, 0 = load).
REQ-007 Port addr0, addr1  input  ADDR_WIDTH each  per-port word address.
REQ-008 Port wdata0, wdata1  input  DATA_WIDTH each  per-port store data.
REQ-009 Port gnt[1:0]  output  2  one-cycle grant pulse; at most one bit set.
REQ-010 Port rvalid[1:0]  output  2  one-cycle load-data-valid pulse.
REQ-011 Port rdata  output  DATA_WIDTH  load data; meaningful only while an rvalid bit is set.
REQ-012 Port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 Port conflict_cnt  output  8  saturating count of cycles in which both req bits were sampled together.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-015 IDLE: when any req is high at a clock edge, latch the winner's we/addr/wdata and go to ACCESS; else stay in IDLE.
REQ-016 ACCESS: gnt[winner] high for exactly this cycle; store writes memory at the closing edge; load reads memory into a register at the closing edge; next state RESP.
REQ-017 RESP: rvalid[winner] high for exactly this cycle if the access was a load, 0 for a store; rdata holds the read word; the arbiter samples req as in IDLE, going to ACCESS if any req is high, else IDLE.
REQ-018 Latency: req sampled at edge N -> gnt during cycle N+1 -> rvalid during cycle N+2; peak throughput one access per 2 cycles.
REQ-019 Requesters hold req/we/addr/wdata stable until gnt and drop req the cycle after gnt; the arbiter ignores req while in ACCESS.
REQ-020 Arbitration (default build): fixed priority, port 0 always beats port 1.
REQ-021 conflict_cnt increments by 1 on each sampling edge (IDLE or RESP) with req == 2'b11, and saturates at 255.
REQ-022 A load in RESP and a new grant to the other port in the following ACCESS SHALL not corrupt rdata: rdata changes only at the closing edge of an ACCESS that performs a load.
REQ-023 Address is used modulo 2^ADDR_WIDTH; there is no out-of-range trap.

Reset
REQ-024 nreset low SHALL immediately force: state IDLE, gnt 0, rvalid 0, busy 0, rdata 0, conflict_cnt 0, round-robin pointer to "last = port 1".
REQ-025 Reset asserted during ACCESS SHALL suppress the pending write; memory contents are not reset.

Configuration
REQ-026 Macro DMEM_ARB_RR_EN: when defined, arbitration is round-robin; on a tie the port not granted most recently wins, and the pointer updates on every grant.
REQ-027 Without DMEM_ARB_RR_EN, fixed priority per REQ-020 applies and no pointer register exists.

Structure
REQ-028 Shared package cpu_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the FSM state enumeration (IDLE, ACCESS, RESP) and the port index constants PORT_CPU = 0 and PORT_DBG = 1.
REQ-029 The storage array SHALL be a sub-module dmem_ram: single port, synchronous write, registered read; the arbiter alone drives it.

Verification
REQ-030 Store then load on port 0: store addr 3 with wdata 0xDEADBEEF -> gnt0 at N+1 with rvalid0 never set; then load addr 3 -> gnt0 at M+1, rvalid0 at M+2 with rdata 0xDEADBEEF.
REQ-031 Simultaneous loads on addr 1 and addr 2, default build -> port 0 granted first and port 1 granted in the following ACCESS; conflict_cnt = 1.
REQ-032 With DMEM_ARB_RR_EN, both ports requesting continuously for 8 grants -> grants alternate 0,1,0,1...; without the macro, port 0 gets all 8 grants.
REQ-033 Assert nreset during ACCESS of a store to addr 7 whose old content is 0x11 -> all outputs 0 at once; a later load of addr 7 returns 0x11.
REQ-034 Hold both req high for 300 sampling edges -> conflict_cnt saturates at 255 and does not wrap.
REQ-035 Address wrap: store to addr 31 then load addr 31 (no aliasing to addr 0) -> the stored value is returned and addr 0 is unchanged.
